// File: rtl/spi_bus_arb.sv
// Round-robin arbiter that lets N bus masters share one spi core register port.
// A master keeps the port for a whole transaction; an optional watchdog revokes hogging owners.
module spi_bus_arb #(
  parameter int N       = 2,
  parameter int AW      = 5,
  parameter int TIMEOUT = 0
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [N-1:0]    m_req,
  input  logic [N*AW-1:0] m_addr,
  input  logic [N-1:0]    m_we,
  input  logic [N-1:0]    m_re,
  input  logic [N*32-1:0] m_wd,
  output logic [N*32-1:0] m_rd,
  output logic [N-1:0]    m_gnt,
  output logic [N-1:0]    m_to,
  output logic [AW-1:0]   s_addr,
  output logic            s_we,
  output logic            s_re,
  output logic [31:0]     s_wd,
  input  logic [31:0]     s_rd
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [15:0] CNT_LIM = (TIMEOUT > 0) ? 16'(TIMEOUT - 1) : 16'hFFFF;

  typedef enum logic {IDLE, OWNED} state_t;

  state_t        state;
  logic [IW-1:0] owner;
  logic [IW-1:0] rr_ptr;
  logic [N-1:0]  blocked;
  logic [15:0]   wd_cnt;

  logic [N-1:0]  eligible;
  logic [N-1:0]  others;
  logic [IW-1:0] idle_pick;
  logic [IW-1:0] next_pick;
  logic          revoke;

  function automatic logic [IW-1:0] succ(input logic [IW-1:0] idx);
    logic [IW-1:0] res;
    if (int'(idx) == N - 1) res = '0;
    else res = idx + 1'b1;
    return res;
  endfunction

  // First set bit of el scanning upward from start with wrap-around.
  function automatic logic [IW-1:0] pick(input logic [N-1:0] el, input logic [IW-1:0] start);
    logic [IW-1:0] idx;
    logic [IW-1:0] res;
    logic          found;
    idx   = start;
    res   = start;
    found = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!found && el[idx]) begin
        res   = idx;
        found = 1'b1;
      end
      idx = succ(idx);
    end
    return res;
  endfunction

  function automatic logic [N-1:0] onehot(input logic [IW-1:0] idx);
    logic [N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  always_comb begin
    eligible        = m_req & ~blocked;
    others          = eligible;
    others[owner]   = 1'b0;
    idle_pick       = pick(eligible, rr_ptr);
    next_pick       = pick(eligible, succ(owner));
    revoke          = (TIMEOUT > 0) && (state == OWNED) && m_req[owner] &&
                      (wd_cnt == CNT_LIM) && (|others);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      m_gnt   <= '0;
      m_to    <= '0;
      owner   <= '0;
      rr_ptr  <= '0;
      blocked <= '0;
      wd_cnt  <= '0;
    end else begin
      m_to    <= '0;
      blocked <= blocked & m_req;
      case (state)
        IDLE: begin
          if (|eligible) begin
            state  <= OWNED;
            owner  <= idle_pick;
            m_gnt  <= onehot(idle_pick);
            wd_cnt <= '0;
          end
        end
        OWNED: begin
          if (!m_req[owner]) begin
            // Release hands over in the same edge so the port never sits idle between owners.
            rr_ptr <= succ(owner);
            wd_cnt <= '0;
            if (|eligible) begin
              owner <= next_pick;
              m_gnt <= onehot(next_pick);
            end else begin
              state <= IDLE;
              m_gnt <= '0;
            end
          end else if (revoke) begin
            rr_ptr  <= succ(owner);
            owner   <= next_pick;
            m_gnt   <= onehot(next_pick);
            m_to    <= onehot(owner);
            blocked <= (blocked & m_req) | onehot(owner);
            wd_cnt  <= '0;
          end else if ((|others) && (wd_cnt != CNT_LIM)) begin
            wd_cnt <= wd_cnt + 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          m_gnt <= '0;
        end
      endcase
    end
  end

  always_comb begin
    s_addr = '0;
    s_wd   = '0;
    s_we   = 1'b0;
    s_re   = 1'b0;
    m_rd   = '0;
    if (m_gnt[owner]) begin
      s_addr                      = m_addr[int'(owner)*AW +: AW];
      s_wd                        = m_wd[int'(owner)*32 +: 32];
      s_we                        = m_we[owner];
      s_re                        = m_re[owner];
      m_rd[int'(owner)*32 +: 32]  = s_rd;
    end
  end

  // Structural invariants of the grant logic.
  a_gnt_onehot: assert property (@(posedge clk) $onehot0(m_gnt));
  a_to_onehot:  assert property (@(posedge clk) $onehot0(m_to));
  a_state_gnt:  assert property (@(posedge clk) (state == IDLE) == (m_gnt == '0));

endmodule

// File: tb/tb_spi_bus_arb.sv
// Self-checking bench for spi_bus_arb: directed scenarios plus randomized traffic,
// every cycle compared against a rule-level reference model of ownership and a model register file.
module tb_spi_bus_arb;

  localparam int N       = 3;
  localparam int AW      = 5;
  localparam int TIMEOUT = 16;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [N-1:0]    m_req = '0;
  logic [N*AW-1:0] m_addr = '0;
  logic [N-1:0]    m_we = '0;
  logic [N-1:0]    m_re = '0;
  logic [N*32-1:0] m_wd = '0;
  logic [N*32-1:0] m_rd;
  logic [N-1:0]    m_gnt;
  logic [N-1:0]    m_to;
  logic [AW-1:0]   s_addr;
  logic            s_we;
  logic            s_re;
  logic [31:0]     s_wd;
  logic [31:0]     s_rd;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] core_regs [32];
  logic        core_clear = 1'b1;

  int          mo_owner;
  int          mo_ptr;
  int          mo_cnt;
  bit [N-1:0]  mo_blk;
  bit [N-1:0]  mo_to;
  logic [31:0] mo_regs [32];

  always #5 clk = ~clk;

  spi_bus_arb #(.N(N), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstn(rstn), .m_req(m_req), .m_addr(m_addr), .m_we(m_we), .m_re(m_re),
    .m_wd(m_wd), .m_rd(m_rd), .m_gnt(m_gnt), .m_to(m_to), .s_addr(s_addr), .s_we(s_we),
    .s_re(s_re), .s_wd(s_wd), .s_rd(s_rd)
  );

  // Stand-in for the spi core register file.
  always @(posedge clk) begin
    if (core_clear) begin
      for (int i = 0; i < 32; i++) core_regs[i] <= '0;
    end else if (s_we) begin
      core_regs[s_addr] <= s_wd;
    end
  end
  assign s_rd = core_regs[s_addr];

  task automatic checkOutput(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int first_from(input bit [N-1:0] el, input int start);
    for (int j = 0; j < N; j++) begin
      if (el[(start + j) % N]) return (start + j) % N;
    end
    return -1;
  endfunction

  task automatic checkAll();
    logic [N-1:0]    e_gnt;
    logic [AW-1:0]   e_addr;
    logic [31:0]     e_wd;
    logic            e_we;
    logic            e_re;
    logic [N*32-1:0] e_rd;
    e_gnt  = '0;
    e_addr = '0;
    e_wd   = '0;
    e_we   = 1'b0;
    e_re   = 1'b0;
    e_rd   = '0;
    if (mo_owner >= 0) begin
      e_gnt[mo_owner]            = 1'b1;
      e_addr                     = m_addr[mo_owner*AW +: AW];
      e_wd                       = m_wd[mo_owner*32 +: 32];
      e_we                       = m_we[mo_owner];
      e_re                       = m_re[mo_owner];
      e_rd[mo_owner*32 +: 32]    = mo_regs[e_addr];
    end
    checkOutput("m_gnt", 128'(m_gnt), 128'(e_gnt));
    checkOutput("m_to", 128'(m_to), 128'(mo_to));
    checkOutput("s_we", 128'(s_we), 128'(e_we));
    checkOutput("s_re", 128'(s_re), 128'(e_re));
    checkOutput("s_addr", 128'(s_addr), 128'(e_addr));
    checkOutput("s_wd", 128'(s_wd), 128'(e_wd));
    checkOutput("m_rd", 128'(m_rd), 128'(e_rd));
  endtask

  task automatic modelEdge();
    bit [N-1:0] el;
    bit [N-1:0] oth;
    bit [N-1:0] nblk;
    bit [N-1:0] nto;
    if (mo_owner >= 0 && m_we[mo_owner]) mo_regs[m_addr[mo_owner*AW +: AW]] = m_wd[mo_owner*32 +: 32];
    if (!rstn) begin
      mo_owner = -1;
      mo_ptr   = 0;
      mo_cnt   = 0;
      mo_blk   = '0;
      mo_to    = '0;
      return;
    end
    el   = m_req & ~mo_blk;
    nblk = mo_blk & m_req;
    nto  = '0;
    if (mo_owner < 0) begin
      if (el != 0) begin
        mo_owner = first_from(el, mo_ptr);
        mo_cnt   = 0;
      end
    end else if (!m_req[mo_owner]) begin
      mo_ptr   = (mo_owner + 1) % N;
      mo_owner = first_from(el, mo_ptr);
      mo_cnt   = 0;
    end else begin
      oth = el;
      oth[mo_owner] = 1'b0;
      if (oth != 0 && mo_cnt == TIMEOUT - 1) begin
        nto[mo_owner]  = 1'b1;
        nblk[mo_owner] = 1'b1;
        mo_ptr   = (mo_owner + 1) % N;
        mo_owner = first_from(oth, mo_ptr);
        mo_cnt   = 0;
      end else if (oth != 0 && mo_cnt < TIMEOUT - 1) begin
        mo_cnt++;
      end
    end
    mo_blk = nblk;
    mo_to  = nto;
  endtask

  task automatic applyStimulus(input logic [N-1:0] req, input logic [N-1:0] we, input logic [N-1:0] re,
                               input logic [N*AW-1:0] addr, input logic [N*32-1:0] wd);
    m_req  = req;
    m_we   = we;
    m_re   = re;
    m_addr = addr;
    m_wd   = wd;
    #1;
    checkAll();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
  endtask

  task automatic idleReq(input logic [N-1:0] req);
    applyStimulus(req, '0, '0, '0, '0);
  endtask

  initial begin
    logic [N-1:0] cur;
    logic [N-1:0] rq;
    mo_owner = -1;
    mo_ptr   = 0;
    mo_cnt   = 0;
    mo_blk   = '0;
    mo_to    = '0;
    for (int i = 0; i < 32; i++) mo_regs[i] = '0;
    @(negedge clk);
    core_clear = 1'b0;

    rstn = 1'b0;
    idleReq('0);
    idleReq('0);
    checkOutput("reset_gnt", 128'(m_gnt), 128'(0));
    checkOutput("reset_s", 128'({s_we, s_re, s_addr, s_wd}), 128'(0));
    rstn = 1'b1;

    // Single master grant latency and write pass-through.
    idleReq(3'b001);
    checkOutput("t1_gnt", 128'(m_gnt), 128'(3'b001));
    applyStimulus(3'b001, 3'b001, 3'b000, {5'd0, 5'd0, 5'd4}, {32'h0, 32'h0, 32'hA5});
    checkOutput("t1_s_we", 128'(s_we), 128'(1));
    checkOutput("t1_s_addr", 128'(s_addr), 128'(4));
    checkOutput("t1_s_wd", 128'(s_wd), 128'(32'hA5));
    checkOutput("t1_core_reg", 128'(core_regs[4]), 128'(32'hA5));

    // Simultaneous requests: m0 wins, then zero-gap handover.
    rstn = 1'b0;
    idleReq('0);
    rstn = 1'b1;
    idleReq(3'b011);
    checkOutput("t2_first", 128'(m_gnt), 128'(3'b001));
    idleReq(3'b011);
    idleReq(3'b010);
    checkOutput("t2_handover", 128'(m_gnt), 128'(3'b010));

    // Alternating ownership under continuous demand.
    for (int r = 0; r < 4; r++) begin
      cur = (r % 2 == 0) ? 3'b010 : 3'b001;
      for (int c = 0; c < 3; c++) idleReq(3'b011);
      idleReq(3'b011 & ~cur);
      checkOutput("t3_alternate", 128'(m_gnt), 128'(3'b011 & ~cur));
    end

    // Non-owner write is dropped; non-owner read data is zero.
    rstn = 1'b0;
    idleReq('0);
    rstn = 1'b1;
    idleReq(3'b011);
    applyStimulus(3'b011, 3'b010, 3'b001, {5'd0, 5'd7, 5'd4}, {32'h0, 32'hDEAD, 32'h0});
    checkOutput("t4_s_we", 128'(s_we), 128'(0));
    checkOutput("t4_core_reg7", 128'(core_regs[7]), 128'(0));
    checkOutput("t4_m1_rd", 128'(m_rd[63:32]), 128'(0));
    checkOutput("t4_m0_rd", 128'(m_rd[31:0]), 128'(32'hA5));

    // Watchdog revoke after TIMEOUT waiting cycles, then blocking until req drops.
    rstn = 1'b0;
    idleReq('0);
    rstn = 1'b1;
    idleReq(3'b001);
    idleReq(3'b001);
    idleReq(3'b001);
    for (int c = 0; c < TIMEOUT - 1; c++) idleReq(3'b011);
    checkOutput("t5_before", 128'(m_gnt), 128'(3'b001));
    idleReq(3'b011);
    checkOutput("t5_revoke_gnt", 128'(m_gnt), 128'(3'b010));
    checkOutput("t5_to_pulse", 128'(m_to), 128'(3'b001));
    idleReq(3'b011);
    checkOutput("t5_to_end", 128'(m_to), 128'(0));
    idleReq(3'b001);
    checkOutput("t5_blocked", 128'(m_gnt), 128'(0));
    idleReq(3'b000);
    idleReq(3'b001);
    checkOutput("t5_unblocked", 128'(m_gnt), 128'(3'b001));

    // Reset while m1 owns.
    rstn = 1'b0;
    idleReq('0);
    rstn = 1'b1;
    idleReq(3'b010);
    checkOutput("t6_m1_owns", 128'(m_gnt), 128'(3'b010));
    rstn = 1'b0;
    applyStimulus(3'b010, 3'b010, 3'b010, {5'd0, 5'd9, 5'd0}, {32'h0, 32'h1234, 32'h0});
    rstn = 1'b1;
    checkOutput("t6_gnt", 128'(m_gnt), 128'(0));
    checkOutput("t6_s_we_re", 128'({s_we, s_re}), 128'(0));
    idleReq(3'b011);
    checkOutput("t6_m0_wins", 128'(m_gnt), 128'(3'b001));

    // Randomized traffic; master 0 holds long enough to trip the watchdog now and then.
    rq = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, (i == 0) ? 31 : 7) == 0) rq[i] = ~rq[i];
      end
      rstn = ($urandom_range(0, 299) != 0);
      applyStimulus(rq,
                    N'($urandom) & N'($urandom),
                    N'($urandom) & N'($urandom),
                    (N*AW)'({$urandom, $urandom}),
                    {$urandom, $urandom, $urandom});
    end
    rstn = 1'b1;
    idleReq('0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
